// File: rtl/gate_trigger_scheduler.sv
// gate_trigger_scheduler
// Collects one-shot fire pulses from the gate array and hands them, round-robin,
// to the shared wire-propagation engine over a valid/ready handshake. Each frame
// ends with a single gate_reset/frame_done pulse so the gates can fire again.
// Optional build macro: SCHED_STATS_EN adds the stat_last / stat_max outputs.
module gate_trigger_scheduler #(
    parameter int unsigned N_GATES  = 8,
    parameter int unsigned ID_W     = 3,
    parameter int unsigned MAX_TRIG = 64,
    parameter int unsigned CNT_W    = 7
) (
    input  logic               clk,
    input  logic               logic_reset_n,
    input  logic               frame_start,
    input  logic [N_GATES-1:0] req,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    input  logic               grant_ready,
    input  logic               eng_done,
    output logic               gate_reset,
    output logic               frame_done,
    output logic               frame_busy,
    output logic               overflow
`ifdef SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]   stat_last,
    output logic [CNT_W-1:0]   stat_max
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_WAIT,
        S_FLUSH
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIG);

    state_t             state;
    logic [N_GATES-1:0] pending;
    logic [N_GATES-1:0] clr;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    arb_id;
    logic [ID_W-1:0]    lock_id;
    logic [ID_W-1:0]    sel_id;
    logic [ID_W-1:0]    next_ptr;
    logic               lock;
    logic               found;
    logic               any_pending;
    logic               handshake;
    logic [CNT_W-1:0]   trig_cnt;
    int unsigned        idx;

    // Round-robin search: first pending gate at or after rr_ptr, wrapping to 0
    always_comb begin
        arb_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N_GATES; k++) begin
            idx = (32'(rr_ptr) + k) % N_GATES;
            if (!found && pending[idx]) begin
                found  = 1'b1;
                arb_id = ID_W'(idx);
            end
        end
    end

    // Offer decode; a stalled offer keeps its locked id so late requests cannot reorder it
    always_comb begin
        any_pending = |pending;
        sel_id      = lock ? lock_id : arb_id;
        grant_valid = (state == S_ARB) && any_pending;
        grant_id    = grant_valid ? sel_id : '0;
        handshake   = grant_valid && grant_ready;
        next_ptr    = (32'(sel_id) == N_GATES - 1) ? '0 : sel_id + 1'b1;
        clr         = '0;
        if (handshake) begin
            clr[sel_id] = 1'b1;
        end
        gate_reset  = (state == S_FLUSH);
        frame_done  = (state == S_FLUSH);
        frame_busy  = (state != S_IDLE);
    end

    // Pending trigger flags: new fire pulses win over the handshake clear; FLUSH drops all
    always_ff @(posedge clk or negedge logic_reset_n) begin
        if (!logic_reset_n) begin
            pending <= '0;
        end else if (state == S_FLUSH) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | req;
        end
    end

    // Frame FSM with round-robin pointer, grant counter, overflow flag and offer lock
    always_ff @(posedge clk or negedge logic_reset_n) begin
        if (!logic_reset_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            trig_cnt <= '0;
            overflow <= 1'b0;
            lock     <= 1'b0;
            lock_id  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state    <= S_ARB;
                        trig_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end
                S_ARB: begin
                    if (handshake) begin
                        rr_ptr   <= next_ptr;
                        trig_cnt <= trig_cnt + 1'b1;
                        lock     <= 1'b0;
                        state    <= S_WAIT;
                    end else if (!any_pending) begin
                        lock  <= 1'b0;
                        state <= S_FLUSH;
                    end else begin
                        lock    <= 1'b1;
                        lock_id <= sel_id;
                    end
                end
                S_WAIT: begin
                    if (eng_done) begin
                        if (trig_cnt == MAX_CNT) begin
                            overflow <= 1'b1;
                            state    <= S_FLUSH;
                        end else begin
                            state <= S_ARB;
                        end
                    end
                end
                S_FLUSH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    // Frame statistics captured as each frame is flushed
    always_ff @(posedge clk or negedge logic_reset_n) begin
        if (!logic_reset_n) begin
            stat_last <= '0;
            stat_max  <= '0;
        end else if (state == S_FLUSH) begin
            stat_last <= trig_cnt;
            if (trig_cnt > stat_max) begin
                stat_max <= trig_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gate_trigger_scheduler.sv
// Directed bench for gate_trigger_scheduler with a grant-id scoreboard and a
// simple engine model that pulses eng_done two cycles after each accepted grant.
module tb_gate_trigger_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic [7:0] req;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       grant_ready;
    logic       eng_done;
    logic       gate_reset;
    logic       frame_done;
    logic       frame_busy;
    logic       overflow;
`ifdef SCHED_STATS_EN
    logic [6:0] stat_last;
    logic [6:0] stat_max;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned exp_q[$];
    int unsigned n;
    bit          got;

    gate_trigger_scheduler #(
        .N_GATES  (8),
        .ID_W     (3),
        .MAX_TRIG (4),
        .CNT_W    (7)
    ) dut (
        .clk           (clk),
        .logic_reset_n (rst_n),
        .frame_start   (frame_start),
        .req           (req),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .grant_ready   (grant_ready),
        .eng_done      (eng_done),
        .gate_reset    (gate_reset),
        .frame_done    (frame_done),
        .frame_busy    (frame_busy),
        .overflow      (overflow)
`ifdef SCHED_STATS_EN
        ,
        .stat_last     (stat_last),
        .stat_max      (stat_max)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: accepts grants, scores their ids, returns at the gate_reset cycle
    task automatic serve(input int unsigned budget, input logic [7:0] rereq,
                         output int unsigned ngr, output bit seen_reset);
        int unsigned cd;
        int unsigned exp_id;
        cd         = 0;
        ngr        = 0;
        seen_reset = 1'b0;
        for (int unsigned c = 0; c < budget; c++) begin
            if (gate_reset) begin
                check("frame_done_with_gate_reset", frame_done, 1);
                seen_reset = 1'b1;
                break;
            end
            eng_done = 1'b0;
            req      = '0;
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    eng_done = 1'b1;
                    req      = rereq;
                end
            end
            if (grant_valid && grant_ready) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL sb_unexpected_grant: observed id %0d expected no grant", grant_id);
                end
                if (exp_q.size() != 0) begin
                    exp_id = exp_q.pop_front();
                    check("sb_grant_id", grant_id, exp_id);
                end
                ngr++;
                cd = 2;
            end
            tick();
        end
        eng_done = 1'b0;
        req      = '0;
        vectors++;
        assert (seen_reset) else begin
            miscompares++;
            $error("FAIL frame_timeout: observed no gate_reset expected one within %0d cycles", budget);
        end
        check("sb_leftover", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        req         = '0;
        grant_ready = 1'b1;
        eng_done    = 1'b0;
        tick();
        tick();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_gate_reset", gate_reset, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_busy", frame_busy, 0);
        check("rst_overflow", overflow, 0);
`ifdef SCHED_STATS_EN
        check("rst_stat_last", stat_last, 0);
        check("rst_stat_max", stat_max, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Two requests: grant 0 then 2, then one-cycle gate_reset
        req = 8'h05; frame_start = 1'b1;
        exp_q.push_back(0); exp_q.push_back(2);
        tick();
        frame_start = 1'b0; req = '0;
        check("t1_valid_t_plus_1", grant_valid, 1);
        check("t1_busy", frame_busy, 1);
        serve(40, 8'h00, n, got);
        check("t1_grants", n, 2);
        check("t1_busy_in_flush", frame_busy, 1);
        tick();
        check("t1_gate_reset_one_cycle", gate_reset, 0);
        check("t1_busy_fall", frame_busy, 0);
`ifdef SCHED_STATS_EN
        check("t1_stat_last", stat_last, 2);
        check("t1_stat_max", stat_max, 2);
`endif

        // rr_ptr is 3 here: 7 then wrap to 0
        req = 8'h81; frame_start = 1'b1;
        exp_q.push_back(7); exp_q.push_back(0);
        tick();
        frame_start = 1'b0; req = '0;
        serve(40, 8'h00, n, got);
        check("t2_grants", n, 2);
        tick();

        // Stalled offer holds its id while lower-index requests arrive (rr_ptr is 1)
        grant_ready = 1'b0;
        req = 8'h08; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; req = '0;
        check("t3_first_valid", grant_valid, 1);
        check("t3_first_id", grant_id, 3);
        for (int i = 0; i < 5; i++) begin
            req = (i % 2 == 1) ? 8'h02 : 8'h04;
            tick();
            check("t3_hold_valid", grant_valid, 1);
            check("t3_hold_id", grant_id, 3);
        end
        req = '0;
        grant_ready = 1'b1;
        exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(2);
        serve(60, 8'h00, n, got);
        check("t3_grants", n, 3);
        tick();

        // Empty frame: gate_reset at t+2, never valid
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t4_empty_valid", grant_valid, 0);
        check("t4_empty_no_reset_t1", gate_reset, 0);
        tick();
        check("t4_empty_reset_t2", gate_reset, 1);
        check("t4_empty_valid_t2", grant_valid, 0);
        tick();
        check("t4_empty_idle", frame_busy, 0);
`ifdef SCHED_STATS_EN
        check("t4_stat_last", stat_last, 0);
        check("t4_stat_max", stat_max, 3);
`endif

        // frame_start during WAIT must not disturb the frame
        req = 8'h20; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; req = '0;
        check("t4b_id", grant_id, 5);
        tick();
        check("t4b_wait_valid", grant_valid, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t4b_ignored_reset_a", gate_reset, 0);
        tick();
        check("t4b_ignored_reset_b", gate_reset, 0);
        check("t4b_ignored_busy", frame_busy, 1);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("t4b_arb_empty_valid", grant_valid, 0);
        tick();
        check("t4b_flush", gate_reset, 1);
        tick();

        // Overflow: gate 1 re-fires on every eng_done, frame stops after 4 grants
        req = 8'h02; frame_start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(1);
        tick();
        frame_start = 1'b0; req = '0;
        serve(80, 8'h02, n, got);
        check("t5_grants", n, 4);
        check("t5_overflow_in_flush", overflow, 1);
        tick();
        check("t5_overflow_sticky", overflow, 1);
        check("t5_idle", frame_busy, 0);
`ifdef SCHED_STATS_EN
        check("t5_stat_last", stat_last, 4);
        check("t5_stat_max", stat_max, 4);
`endif
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("t5_overflow_cleared", overflow, 0);
        check("t5_pending_flushed", grant_valid, 0);
        tick();
        check("t5_empty_reset", gate_reset, 1);
        tick();
`ifdef SCHED_STATS_EN
        check("t5_stat_max_holds", stat_max, 4);
`endif

        // Asynchronous reset in WAIT aborts the frame with no gate_reset
        req = 8'h50; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; req = '0;
        check("t6_id", grant_id, 4);
        tick();
        check("t6_in_wait", frame_busy, 1);
        #2;
        rst_n = 1'b0;
        eng_done = 1'b1;
        #1;
        check("t6_rst_valid", grant_valid, 0);
        check("t6_rst_id", grant_id, 0);
        check("t6_rst_gate_reset", gate_reset, 0);
        check("t6_rst_frame_done", frame_done, 0);
        check("t6_rst_busy", frame_busy, 0);
        check("t6_rst_overflow", overflow, 0);
        tick();
        check("t6_rst_no_pulse", gate_reset, 0);
        rst_n = 1'b1;
        eng_done = 1'b0;
        tick();
        check("t6_after_rst_reset", gate_reset, 0);
`ifdef SCHED_STATS_EN
        check("t6_stat_last", stat_last, 0);
        check("t6_stat_max", stat_max, 0);
`endif
        // pending and rr_ptr cleared: 0 then 7, gate 6 gone
        req = 8'h81; frame_start = 1'b1;
        exp_q.push_back(0); exp_q.push_back(7);
        tick();
        frame_start = 1'b0; req = '0;
        serve(40, 8'h00, n, got);
        check("t6_grants", n, 2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
